// File: rtl/servo_pwm_multi.sv
// Multi-channel hobby-servo PWM generator sharing one frame counter.
// Widths are clamped on write and applied only at frame boundaries, optionally slew-limited.
module servo_pwm_multi #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned CNT_W      = 18,
  parameter int unsigned PERIOD     = 240000,
  parameter int unsigned MIN_WIDTH  = 6000,
  parameter int unsigned MAX_WIDTH  = 28800,
  parameter int unsigned INIT_WIDTH = 17400,
  parameter int unsigned SLEW       = 0,
  parameter int unsigned ACTIVE_LOW = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [3:0]        wr_ch,
  input  logic [CNT_W-1:0]  wr_width,
  output logic              wr_err,
  input  logic [NUM_CH-1:0] en,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              frame_start,
  output logic [NUM_CH-1:0] settled
);

  localparam logic [CNT_W-1:0]        LAST_CNT = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0]        MIN_W    = CNT_W'(MIN_WIDTH);
  localparam logic [CNT_W-1:0]        MAX_W    = CNT_W'(MAX_WIDTH);
  localparam logic [CNT_W-1:0]        INIT_W   = CNT_W'(INIT_WIDTH);
  localparam logic [CNT_W-1:0]        SLEW_W   = CNT_W'(SLEW);
  localparam logic signed [CNT_W:0]   SLEW_S   = $signed((CNT_W+1)'(SLEW));
  localparam logic                    IDLE_LVL = 1'(ACTIVE_LOW != 0);

  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [CNT_W-1:0]  target_q   [NUM_CH];
  logic [CNT_W-1:0]  target_nxt [NUM_CH];
  logic [CNT_W-1:0]  active_q   [NUM_CH];
  logic [CNT_W-1:0]  active_nxt [NUM_CH];
  logic [NUM_CH-1:0] pwm_nxt;
  logic [NUM_CH-1:0] settled_nxt;
  logic              wrap;
  logic              wr_fire;
  logic              ch_ok;

  function automatic logic [CNT_W-1:0] clamp_width(input logic [CNT_W-1:0] w);
    logic [CNT_W-1:0] res;
    res = w;
    if (w < MIN_W)      res = MIN_W;
    else if (w > MAX_W) res = MAX_W;
    return res;
  endfunction

  // Boundary move of the active width toward the target; disabled channels snap.
  function automatic logic [CNT_W-1:0] step_width(input logic [CNT_W-1:0] act,
                                                  input logic [CNT_W-1:0] tgt,
                                                  input logic             ena);
    logic signed [CNT_W:0] diff;
    logic signed [CNT_W:0] mag;
    logic [CNT_W-1:0]      res;
    diff = $signed({1'b0, tgt}) - $signed({1'b0, act});
    mag  = diff[CNT_W] ? -diff : diff;
    if (SLEW == 0 || !ena || mag <= SLEW_S) res = tgt;
    else if (diff[CNT_W])                    res = act - SLEW_W;
    else                                     res = act + SLEW_W;
    return res;
  endfunction

  always_comb begin
    wrap    = (cnt_q == LAST_CNT);
    cnt_nxt = wrap ? '0 : cnt_q + CNT_W'(1);
    wr_fire = wr_valid && wr_ready;
    ch_ok   = ({1'b0, wr_ch} < 5'(NUM_CH));
    pwm_nxt     = '0;
    settled_nxt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      target_nxt[i] = target_q[i];
      active_nxt[i] = active_q[i];
      if (wr_fire && ch_ok && (wr_ch == 4'(i)))
        target_nxt[i] = clamp_width(wr_width);
      if (wrap)
        active_nxt[i] = step_width(active_q[i], target_q[i], en[i]);
      pwm_nxt[i]     = (en[i] && (cnt_nxt < active_nxt[i])) ^ IDLE_LVL;
      settled_nxt[i] = (active_q[i] == target_q[i]);
    end
  end

  // Outputs are registered against the counter value they will accompany.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= LAST_CNT;
      for (int i = 0; i < NUM_CH; i++) begin
        target_q[i] <= INIT_W;
        active_q[i] <= INIT_W;
      end
      pwm_out     <= {NUM_CH{IDLE_LVL}};
      frame_start <= 1'b0;
      wr_err      <= 1'b0;
      wr_ready    <= 1'b1;
      settled     <= '1;
    end else begin
      cnt_q       <= cnt_nxt;
      for (int i = 0; i < NUM_CH; i++) begin
        target_q[i] <= target_nxt[i];
        active_q[i] <= active_nxt[i];
      end
      pwm_out     <= pwm_nxt;
      frame_start <= (cnt_nxt == '0);
      wr_err      <= wr_fire && !ch_ok;
      wr_ready    <= (cnt_nxt != LAST_CNT);
      settled     <= settled_nxt;
    end
  end

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Directed scoreboard bench for servo_pwm_multi: one unlimited-slew and one SLEW=5 instance.
module tb_servo_pwm_multi;

  localparam int unsigned CW = 18;

  logic          clk;
  logic          rst_n;
  logic          wr_valid, wr_valid_s;
  logic          wr_ready, wr_ready_s;
  logic [3:0]    wr_ch;
  logic [CW-1:0] wr_width;
  logic          wr_err, wr_err_s;
  logic [1:0]    en;
  logic [1:0]    pwm, pwm_s;
  logic          fs, fs_s;
  logic [1:0]    settled, settled_s;

  typedef struct {
    int w0; int w1; int s0; int s1; int err; int st; int st_s;
  } fexp_t;

  fexp_t sbq[$];
  int    errors = 0;
  int    checks = 0;
  int    fidx = 0;
  int    sched_k = -1, sched_len = 0, sched_ch = 0, sched_w = 0, sched_s = 0;
  int    hold_left = 0;

  servo_pwm_multi #(.NUM_CH(2), .CNT_W(CW), .PERIOD(100), .MIN_WIDTH(10), .MAX_WIDTH(80),
                    .INIT_WIDTH(40), .SLEW(0), .ACTIVE_LOW(0)) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_ch(wr_ch),
    .wr_width(wr_width), .wr_err(wr_err), .en(en), .pwm_out(pwm), .frame_start(fs),
    .settled(settled));

  servo_pwm_multi #(.NUM_CH(2), .CNT_W(CW), .PERIOD(100), .MIN_WIDTH(10), .MAX_WIDTH(80),
                    .INIT_WIDTH(40), .SLEW(5), .ACTIVE_LOW(0)) dut_s (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid_s), .wr_ready(wr_ready_s), .wr_ch(wr_ch),
    .wr_width(wr_width), .wr_err(wr_err_s), .en(en), .pwm_out(pwm_s), .frame_start(fs_s),
    .settled(settled_s));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before 1000000");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int w0, input int w1, input int s0, input int s1,
                      input int err, input int st, input int st_s);
    fexp_t e;
    e.w0 = w0; e.w1 = w1; e.s0 = s0; e.s1 = s1; e.err = err; e.st = st; e.st_s = st_s;
    sbq.push_back(e);
  endtask

  task automatic schedule(input int k, input int len, input int ch, input int w, input int s);
    sched_k = k; sched_len = len; sched_ch = ch; sched_w = w; sched_s = s;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_pwm"},     32'(pwm),       0);
    check({tag, "_pwm_s"},   32'(pwm_s),     0);
    check({tag, "_fs"},      32'({fs, fs_s}), 0);
    check({tag, "_err"},     32'({wr_err, wr_err_s}), 0);
    check({tag, "_ready"},   32'({wr_ready, wr_ready_s}), 3);
    check({tag, "_settled"}, 32'({settled, settled_s}), 15);
  endtask

  // Observe one full frame (cnt 0..99), drive scheduled writes, then score it.
  task automatic measure_frame();
    fexp_t      e;
    int         tot[4];
    int         lead[4];
    bit         open[4];
    int         fs_bad, hs_bad, err_cnt, err_k, err_obs;
    logic [3:0] p;
    logic [1:0] st, st_s;
    fs_bad = 0; hs_bad = 0; err_cnt = 0; err_k = -1;
    st = 'x; st_s = 'x;
    for (int j = 0; j < 4; j++) begin tot[j] = 0; lead[j] = 0; open[j] = 1'b1; end
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      p = {pwm_s, pwm};
      for (int j = 0; j < 4; j++) begin
        if (p[j] === 1'b1) begin
          tot[j]++;
          if (open[j]) lead[j]++;
        end else open[j] = 1'b0;
      end
      if (fs !== (k == 0) || fs_s !== (k == 0)) fs_bad++;
      if (wr_ready !== (k != 99) || wr_ready_s !== (k != 99)) hs_bad++;
      if (wr_err_s !== 1'b0) hs_bad++;
      if (wr_err === 1'b1) begin err_cnt++; err_k = k; end
      else if (wr_err !== 1'b0) err_cnt += 100;
      if (k == 99) begin st = settled; st_s = settled_s; end
      if (hold_left > 0) begin
        hold_left--;
        if (hold_left == 0) begin wr_valid = 1'b0; wr_valid_s = 1'b0; end
      end
      if (k == sched_k) begin
        wr_ch    = 4'(sched_ch);
        wr_width = CW'(sched_w);
        if (sched_s != 0) wr_valid_s = 1'b1;
        else              wr_valid   = 1'b1;
        hold_left = sched_len;
        sched_k   = -1;
      end
    end
    fidx++;
    if (sbq.size() == 0) begin
      checks++; errors++;
      $error("FAIL f%0d_scoreboard: observed empty queue, expected an entry", fidx);
    end else begin
      e = sbq.pop_front();
      err_obs = (err_cnt == 0) ? -1 : ((err_cnt == 1) ? err_k : 1000 + err_cnt);
      check($sformatf("f%0d_w0", fidx),      tot[0],  e.w0);
      check($sformatf("f%0d_w0_lead", fidx), lead[0], e.w0);
      check($sformatf("f%0d_w1", fidx),      tot[1],  e.w1);
      check($sformatf("f%0d_w1_lead", fidx), lead[1], e.w1);
      check($sformatf("f%0d_s0", fidx),      tot[2],  e.s0);
      check($sformatf("f%0d_s0_lead", fidx), lead[2], e.s0);
      check($sformatf("f%0d_s1", fidx),      tot[3],  e.s1);
      check($sformatf("f%0d_s1_lead", fidx), lead[3], e.s1);
      check($sformatf("f%0d_err_at", fidx),  err_obs, e.err);
      check($sformatf("f%0d_fs_bad", fidx),  fs_bad,  0);
      check($sformatf("f%0d_hs_bad", fidx),  hs_bad,  0);
      check($sformatf("f%0d_settled", fidx), 32'(st),   e.st);
      check($sformatf("f%0d_settled_s", fidx), 32'(st_s), e.st_s);
    end
  endtask

  initial begin
    rst_n = 1'b0; wr_valid = 1'b0; wr_valid_s = 1'b0; wr_ch = '0; wr_width = '0; en = 2'b11;
    repeat (3) @(negedge clk);
    check_reset("rst0");
    rst_n = 1'b1;

    // Steady frames at the initial width
    push(40, 40, 40, 40, -1, 3, 3); measure_frame();
    push(40, 40, 40, 40, -1, 3, 3); measure_frame();

    // Mid-frame write lands on the following frame only
    schedule(10, 1, 0, 25, 0);
    push(40, 40, 40, 40, -1, 2, 3); measure_frame();
    push(25, 40, 40, 40, -1, 3, 3); measure_frame();

    // Clamp low, clamp high, out-of-range channel
    schedule(10, 1, 1, 5, 0);
    push(25, 40, 40, 40, -1, 1, 3); measure_frame();
    schedule(10, 1, 1, 200, 0);
    push(25, 10, 40, 40, -1, 1, 3); measure_frame();
    schedule(10, 1, 3, 30, 0);
    push(25, 80, 40, 40, 11, 3, 3); measure_frame();
    push(25, 80, 40, 40, -1, 3, 3); measure_frame();

    // Slew-limited move 40 -> 60 in steps of 5
    schedule(10, 1, 0, 60, 1);
    push(25, 80, 40, 40, -1, 3, 2); measure_frame();
    push(25, 80, 45, 40, -1, 3, 2); measure_frame();
    push(25, 80, 50, 40, -1, 3, 2); measure_frame();
    push(25, 80, 55, 40, -1, 3, 2); measure_frame();
    push(25, 80, 60, 40, -1, 3, 3); measure_frame();

    // Disabled channel is silent and snaps past the slew limit
    en = 2'b01;
    schedule(10, 1, 1, 80, 1);
    push(25, 0, 60, 0, -1, 3, 1); measure_frame();
    push(25, 0, 60, 0, -1, 3, 3); measure_frame();
    en = 2'b11;
    push(25, 80, 60, 80, -1, 3, 3); measure_frame();

    // Write held across the boundary cycle is accepted at cnt 0
    schedule(99, 2, 0, 70, 0);
    push(25, 80, 60, 80, -1, 3, 3); measure_frame();
    push(25, 80, 60, 80, -1, 2, 3); measure_frame();
    push(70, 80, 60, 80, -1, 3, 3); measure_frame();

    // Asynchronous reset in the middle of a pulse
    for (int k = 0; k <= 20; k++) @(negedge clk);
    check("mid_pulse_pwm",   32'(pwm),   3);
    check("mid_pulse_pwm_s", 32'(pwm_s), 3);
    rst_n = 1'b0;
    #1;
    check("async_rst_pwm",   32'(pwm),   0);
    check("async_rst_pwm_s", 32'(pwm_s), 0);
    @(negedge clk);
    check_reset("rst1");
    rst_n = 1'b1;
    push(40, 40, 40, 40, -1, 3, 3); measure_frame();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
